// File: rtl/freq_div_ctrl.sv
// Programmable clock-level divider with a glitch-free ratio change and a graceful stop.
// Latency: an accepted ratio takes effect on the next cycle from IDLE, or at the next period boundary while running.
// Backpressure: cfg_ready drops while a change or stop is pending, and whenever stop is asserted.
module freq_div_ctrl #(
    parameter int CNT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             cfg_valid,
    input  logic [CNT_W-1:0] cfg_div,
    output logic             cfg_ready,
    input  logic             stop,
    output logic             div_out,
    output logic             div_tick,
    output logic [CNT_W-1:0] cur_div,
    output logic             busy,
    output logic             cfg_err
);

    typedef enum logic [1:0] {
        IDLE      = 2'd0,
        RUN       = 2'd1,
        PEND_CFG  = 2'd2,
        PEND_STOP = 2'd3
    } state_t;

    state_t           state;
    logic [CNT_W-1:0] cnt;      // position inside the current period
    logic [CNT_W-1:0] n_reg;    // ratio currently in use
    logic [CNT_W-1:0] pend;     // ratio waiting for the next period boundary

    logic             cfg_xfer;
    logic             cfg_ok;
    logic             last;
    logic [CNT_W-1:0] cnt_nxt;
    logic [CNT_W-1:0] half;
    logic             out_nxt;
    logic             tick_nxt;

    // Handshake and per-cycle counter arithmetic for the running divider.
    always_comb begin
        cfg_ready = ((state == IDLE) || (state == RUN)) && !stop;
        cfg_xfer  = cfg_valid && cfg_ready;
        cfg_ok    = (cfg_div >= CNT_W'(2));
        last      = (cnt == (n_reg - CNT_W'(1)));
        cnt_nxt   = last ? '0 : (cnt + CNT_W'(1));
        half      = n_reg >> 1;
        out_nxt   = (cnt_nxt < half);
        tick_nxt  = (cnt_nxt == '0);
    end

    assign busy    = (state != IDLE);
    assign cur_div = n_reg;

    // Control FSM with registered divider outputs aligned to cnt.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= IDLE;
            cnt      <= '0;
            n_reg    <= '0;
            pend     <= '0;
            div_out  <= 1'b0;
            div_tick <= 1'b0;
            cfg_err  <= 1'b0;
        end else begin
            // Ratios of 0 or 1 are rejected with a single-cycle flag and no other effect.
            cfg_err <= cfg_xfer && !cfg_ok;
            case (state)
                IDLE: begin
                    if (cfg_xfer && cfg_ok) begin
                        state    <= RUN;
                        n_reg    <= cfg_div;
                        cnt      <= '0;
                        div_out  <= 1'b1;
                        div_tick <= 1'b1;
                    end else begin
                        cnt      <= '0;
                        div_out  <= 1'b0;
                        div_tick <= 1'b0;
                    end
                end
                RUN: begin
                    cnt      <= cnt_nxt;
                    div_out  <= out_nxt;
                    div_tick <= tick_nxt;
                    if (stop) begin
                        state <= PEND_STOP;
                    end else if (cfg_xfer && cfg_ok) begin
                        // The current period always completes; the new ratio waits for the boundary.
                        state <= PEND_CFG;
                        pend  <= cfg_div;
                    end
                end
                PEND_CFG: begin
                    if (stop) begin
                        // Stop overrides the queued ratio, which is simply forgotten.
                        state    <= PEND_STOP;
                        cnt      <= cnt_nxt;
                        div_out  <= out_nxt;
                        div_tick <= tick_nxt;
                    end else if (last) begin
                        // pend >= 2, so the first cycle of the new period is always high.
                        state    <= RUN;
                        n_reg    <= pend;
                        cnt      <= '0;
                        div_out  <= 1'b1;
                        div_tick <= 1'b1;
                    end else begin
                        cnt      <= cnt_nxt;
                        div_out  <= out_nxt;
                        div_tick <= tick_nxt;
                    end
                end
                PEND_STOP: begin
                    if (last) begin
                        // cur_div keeps the last ratio so software can read what was running.
                        state    <= IDLE;
                        cnt      <= '0;
                        div_out  <= 1'b0;
                        div_tick <= 1'b0;
                    end else begin
                        cnt      <= cnt_nxt;
                        div_out  <= out_nxt;
                        div_tick <= tick_nxt;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_freq_div_ctrl.sv
// Scoreboard bench for freq_div_ctrl: directed scenarios followed by random traffic.
// Expected outputs come from a period/plan model, queued at stimulus time and popped by a monitor.
// The monitor samples 1 time unit after each rising edge; inputs change on falling edges.
module tb_freq_div_ctrl;

    localparam int CNT_W = 8;

    logic             clk;
    logic             rst;
    logic             cfg_valid;
    logic [CNT_W-1:0] cfg_div;
    logic             cfg_ready;
    logic             stop;
    logic             div_out;
    logic             div_tick;
    logic [CNT_W-1:0] cur_div;
    logic             busy;
    logic             cfg_err;

    freq_div_ctrl #(.CNT_W(CNT_W)) dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_valid (cfg_valid),
        .cfg_div   (cfg_div),
        .cfg_ready (cfg_ready),
        .stop      (stop),
        .div_out   (div_out),
        .div_tick  (div_tick),
        .cur_div   (cur_div),
        .busy      (busy),
        .cfg_err   (cfg_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        bit dout;
        bit tick;
        bit bsy;
        bit err;
        bit rdy;
        int cur;
    } exp_t;

    exp_t exp_q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: where we are inside the period, and what happens at its end.
    // plan: 0 = keep running, 1 = switch to next_ratio, 2 = halt.
    bit m_active;
    int m_ph;
    int m_ratio;
    int m_plan;
    int m_next;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        m_active = 0;
        m_ph     = 0;
        m_ratio  = 0;
        m_plan   = 0;
        m_next   = 0;
    endtask

    // Advance the model by one clock edge and queue the outputs seen after that edge.
    task automatic model_step(input bit v, input int d, input bit s);
        bit   ready;
        bit   xfer;
        bit   at_end;
        exp_t e;
        ready = (!m_active || m_plan == 0) && !s;
        xfer  = v && ready;
        e.err = xfer && (d < 2);
        if (!m_active) begin
            if (xfer && d >= 2) begin
                m_active = 1;
                m_ratio  = d;
                m_ph     = 0;
                m_plan   = 0;
            end
        end else begin
            at_end = (m_ph == m_ratio - 1);
            if (m_plan == 2 && at_end) begin
                m_active = 0;
                m_ph     = 0;
                m_plan   = 0;
            end else if (m_plan == 1 && at_end && !s) begin
                m_ratio = m_next;
                m_ph    = 0;
                m_plan  = 0;
            end else begin
                m_ph = at_end ? 0 : m_ph + 1;
                if (s) m_plan = 2;
                else if (m_plan == 0 && xfer && d >= 2) begin
                    m_plan = 1;
                    m_next = d;
                end
            end
        end
        e.dout = m_active && (m_ph < m_ratio / 2);
        e.tick = m_active && (m_ph == 0);
        e.bsy  = m_active;
        e.cur  = m_ratio;
        e.rdy  = (!m_active || m_plan == 0) && !s;
        exp_q.push_back(e);
    endtask

    task automatic step(input bit v, input int d, input bit s);
        @(negedge clk);
        cfg_valid = v;
        cfg_div   = CNT_W'(d);
        stop      = s;
        model_step(v, d, s);
    endtask

    // Monitor: compare every post-edge output against the oldest queued expectation.
    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("div_out",   int'(div_out),   int'(e.dout));
                chk("div_tick",  int'(div_tick),  int'(e.tick));
                chk("busy",      int'(busy),      int'(e.bsy));
                chk("cfg_err",   int'(cfg_err),   int'(e.err));
                chk("cfg_ready", int'(cfg_ready), int'(e.rdy));
                chk("cur_div",   int'(cur_div),   e.cur);
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete, expected finish before %0t", $time);
        $fatal(1, "watchdog expired");
    end

    initial begin
        int guard;
        int d;
        bit v;
        bit s;

        rst       = 1'b1;
        cfg_valid = 1'b0;
        cfg_div   = '0;
        stop      = 1'b0;
        model_reset();
        #2;
        chk("rst_div_out",   int'(div_out),   0);
        chk("rst_div_tick",  int'(div_tick),  0);
        chk("rst_busy",      int'(busy),      0);
        chk("rst_cfg_err",   int'(cfg_err),   0);
        chk("rst_cur_div",   int'(cur_div),   0);
        chk("rst_cfg_ready", int'(cfg_ready), 1);
        @(negedge clk);
        rst = 1'b0;

        // Ratio 4 from IDLE, a few full periods.
        step(1, 4, 0);
        repeat (11) step(0, 0, 0);

        // Illegal ratios 1 and 0 while running: flag only.
        step(1, 1, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        repeat (3) step(0, 0, 0);

        // Ratio change to 6 accepted at cnt=1 of an N=4 period.
        guard = 0;
        while (!(m_active && m_plan == 0 && m_ph == 1) && guard < 50) begin
            step(0, 0, 0);
            guard++;
        end
        chk("wait_cnt1", guard < 50, 1);
        step(1, 6, 0);
        repeat (14) step(0, 0, 0);

        // Stop together with a config request at cnt=2 of N=6: stop wins.
        guard = 0;
        while (!(m_active && m_plan == 0 && m_ratio == 6 && m_ph == 2) && guard < 50) begin
            step(0, 0, 0);
            guard++;
        end
        chk("wait_cnt2", guard < 50, 1);
        step(1, 3, 1);
        guard = 0;
        while (m_active && guard < 50) begin
            step(0, 0, 0);
            guard++;
        end
        repeat (2) step(0, 0, 0);

        // Illegal ratio in IDLE, then ratio 5.
        step(1, 1, 0);
        step(0, 0, 0);
        step(1, 0, 0);
        step(0, 0, 0);
        step(1, 5, 0);
        repeat (12) step(0, 0, 0);
        step(0, 0, 1);
        guard = 0;
        while (m_active && guard < 50) begin
            step(0, 0, 0);
            guard++;
        end

        // Asynchronous reset while div_out is high at N=8.
        step(1, 8, 0);
        guard = 0;
        while (m_ph != 1 && guard < 50) begin
            step(0, 0, 0);
            guard++;
        end
        @(negedge clk);
        #2;
        chk("pre_rst_div_out", int'(div_out), 1);
        rst = 1'b1;
        #1;
        chk("async_rst_div_out",  int'(div_out),  0);
        chk("async_rst_busy",     int'(busy),     0);
        chk("async_rst_cur_div",  int'(cur_div),  0);
        chk("async_rst_div_tick", int'(div_tick), 0);
        model_reset();
        @(negedge clk);
        rst = 1'b0;
        repeat (3) step(0, 0, 0);

        // Random traffic.
        for (int i = 0; i < 3000; i++) begin
            v = ($urandom_range(0, 99) < 15);
            s = ($urandom_range(0, 99) < 3);
            if ($urandom_range(0, 9) == 0) d = $urandom_range(0, 40);
            else d = $urandom_range(0, 9);
            step(v, d, s);
        end
        step(0, 0, 0);

        repeat (3) @(posedge clk);
        #2;
        chk("queue_drained", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/freq_div_ctrl.md
FREQ_DIV_CTRL -- requirements
Module: freq_div_ctrl

Interface
REQ-001 The block SHALL have parameter CNT_W, default 8, giving the divide-ratio and period-counter width (ratio range 2..2^CNT_W-1).
REQ-002 The block SHALL have port clk, input, 1, the single clock; all logic rises on posedge clk.
REQ-003 The block SHALL have port rst, input, 1, asynchronous active-high reset.
REQ-004 The block SHALL have port cfg_valid, input, 1, new divide-ratio request.
REQ-005 The block SHALL have port cfg_div, input, CNT_W, requested ratio N, sampled when cfg_valid && cfg_ready.
REQ-006 The block SHALL have port cfg_ready, output, 1, config accept.
REQ-007 The block SHALL have port stop, input, 1, request to halt the divider at the next period boundary.
REQ-008 The block SHALL have port div_out, output, 1, divided clock-level signal (registered).
REQ-009 The block SHALL have port div_tick, output, 1, one-cycle pulse marking the first cycle of each period.
REQ-010 The block SHALL have port cur_div, output, CNT_W, the ratio currently in use.
REQ-011 The block SHALL have port busy, output, 1, high whenever the state is not IDLE.
REQ-012 The block SHALL have port cfg_err, output, 1, one-cycle pulse on an accepted ratio of 0 or 1.

Function
REQ-013 The FSM SHALL have states IDLE, RUN, PEND_CFG and PEND_STOP, plus period counter cnt (CNT_W bits) and held ratio register N.
REQ-014 cfg_ready SHALL equal (state==IDLE || state==RUN) && !stop, combinationally; the transfer is cfg_valid && cfg_ready.
REQ-015 A transfer with cfg_div < 2 SHALL produce cfg_err=1 for the following cycle only, and leave state, cnt, N and outputs unchanged.
REQ-016 A valid transfer in IDLE SHALL load N=cfg_div and go to RUN; the next cycle SHALL have cnt=0, div_out=1, div_tick=1, cur_div=N.
REQ-017 In RUN, cnt SHALL count 0..N-1 and wrap to 0, giving a period of exactly N cycles.
REQ-018 div_out SHALL be 1 while cnt < floor(N/2) and 0 otherwise: 50% duty for even N, and high for (N-1)/2 of N cycles for odd N.
REQ-019 div_tick SHALL be 1 exactly in RUN/PEND cycles where cnt==0.
REQ-020 A valid transfer in RUN SHALL store the pending ratio and go to PEND_CFG; the current period SHALL complete unchanged.
REQ-021 In PEND_CFG or PEND_STOP, cfg_ready SHALL be 0 and the counter and div_out SHALL keep running with the old N.
REQ-022 In PEND_CFG, at the edge where cnt==N-1, the block SHALL load N=pending, set cnt=0 and go to RUN, so the new period starts glitch-free and the old period is never truncated.
REQ-023 stop=1 in RUN or PEND_CFG SHALL move to PEND_STOP; a pending config SHALL be discarded.
REQ-024 stop in IDLE or PEND_STOP SHALL be ignored.
REQ-025 In PEND_STOP, at the edge where cnt==N-1, the block SHALL set cnt=0 and div_out=0 and go to IDLE; cur_div SHALL hold its last value.
REQ-026 When stop and cfg_valid are both high in RUN, stop SHALL win, cfg_ready SHALL be 0, and no transfer SHALL occur.
REQ-027 A valid transfer at the same edge where cnt==N-1 in RUN SHALL still go to PEND_CFG, and the new ratio SHALL apply at the following boundary (one full old period later).
REQ-028 In IDLE, div_out=0, div_tick=0 and cnt=0.

Reset
REQ-029 On rst=1, the block SHALL immediately (asynchronously) force state=IDLE, cnt=0, N=0, cur_div=0, div_out=0, div_tick=0, cfg_err=0 and busy=0; cfg_ready SHALL then follow REQ-014.
REQ-030 Reset asserted mid-period SHALL abandon the period and discard any pending config; after release the block SHALL wait in IDLE for a new config.

Verification
REQ-031 The bench SHALL cover: reset, then cfg_div=4 in IDLE -> div_out 1,1,0,0 repeating, div_tick every 4th cycle, cur_div=4, busy=1.
REQ-032 The bench SHALL cover: cfg_div=5 from IDLE -> div_out 1,1,0,0,0 repeating, period 5.
REQ-033 The bench SHALL cover: cfg_div=1 (and separately 0) -> cfg_err single pulse, state, cur_div and div_out unchanged.
REQ-034 The bench SHALL cover: running N=4, cfg_div=6 accepted at cnt=1 -> cfg_ready=0 until the boundary, cnt 2,3 complete, then div_out 1,1,1,0,0,0 repeating and cur_div=6.
REQ-035 The bench SHALL cover: running N=6, stop at cnt=2 -> period completes through cnt=5, then div_out=0 and busy=0; stop with cfg_valid in the same cycle -> no transfer.
REQ-036 The bench SHALL cover: rst pulsed while div_out=1 at N=8 -> div_out=0, busy=0 and cur_div=0 without waiting for a clock edge.
